// File: rtl/jump_sequencer.sv
// Conditional-jump sequencer: reads one or two register operands, evaluates a
// condition code and produces the next PC together with saturating statistics.
module jump_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  cond,
  input  logic [2:0]  rd_addr,
  input  logic [2:0]  rs_addr,
  input  logic [15:0] imm_n,
  input  logic [15:0] target,
  input  logic [15:0] pc,
  output logic        rf_re,
  output logic [2:0]  rf_addr,
  input  logic [15:0] rf_rdata,
  output logic        busy,
  output logic        done,
  output logic        pc_load,
  output logic [15:0] pc_next,
  output logic        taken,
  output logic [15:0] taken_cnt,
  output logic [15:0] total_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WRD, S_RS, S_WRS, S_EVAL, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cond_q;
  logic [2:0]  rd_addr_q, rs_addr_q;
  logic [15:0] imm_q, target_q, pc_q;
  logic [15:0] rd_val, rs_val;
  logic        taken_q;
  logic        taken_eval;

  // Register-compare codes (00xx) need the second operand.
  wire need_rs = (cond_q[3:2] == 2'b00);

  always_comb begin
    state_nxt = state;
    rf_re     = 1'b0;
    rf_addr   = 3'd0;
    case (state)
      S_IDLE: if (start) state_nxt = S_RD;
      S_RD: begin
        rf_re     = 1'b1;
        rf_addr   = rd_addr_q;
        state_nxt = S_WRD;
      end
      S_WRD:  state_nxt = need_rs ? S_RS : S_EVAL;
      S_RS: begin
        rf_re     = 1'b1;
        rf_addr   = rs_addr_q;
        state_nxt = S_WRS;
      end
      S_WRS:  state_nxt = S_EVAL;
      S_EVAL: state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    taken_eval = 1'b0;
    case (cond_q)
      4'b0000: taken_eval = (rd_val >  rs_val);
      4'b0001: taken_eval = (rd_val <  rs_val);
      4'b0010: taken_eval = (rd_val == rs_val);
      4'b0011: taken_eval = (rd_val != rs_val);
      4'b0100: taken_eval = (rd_val == 16'd0);
      4'b0101: taken_eval = rd_val[15];
      4'b1000: taken_eval = (rd_val >  imm_q);
      4'b1001: taken_eval = (rd_val <  imm_q);
      4'b1010: taken_eval = (rd_val == imm_q);
      4'b1011: taken_eval = (rd_val != imm_q);
      default: taken_eval = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cond_q    <= 4'd0;
      rd_addr_q <= 3'd0;
      rs_addr_q <= 3'd0;
      imm_q     <= 16'd0;
      target_q  <= 16'd0;
      pc_q      <= 16'd0;
      rd_val    <= 16'd0;
      rs_val    <= 16'd0;
      taken_q   <= 1'b0;
      pc_next   <= 16'd0;
      taken_cnt <= 16'd0;
      total_cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (start) begin
          cond_q    <= cond;
          rd_addr_q <= rd_addr;
          rs_addr_q <= rs_addr;
          imm_q     <= imm_n;
          target_q  <= target;
          pc_q      <= pc;
        end
        S_WRD: rd_val <= rf_rdata;
        S_WRS: rs_val <= rf_rdata;
        // Result and statistics land together on the edge entering DONE.
        S_EVAL: begin
          taken_q   <= taken_eval;
          pc_next   <= taken_eval ? target_q : pc_q + 16'd1;
          total_cnt <= (total_cnt == 16'hFFFF) ? total_cnt : total_cnt + 16'd1;
          if (taken_eval && taken_cnt != 16'hFFFF)
            taken_cnt <= taken_cnt + 16'd1;
        end
        S_DONE: taken_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign pc_load = done;
  assign taken   = taken_q;

endmodule
